// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus carry flop, LSB first, WIDTH cycles per operation.
// Optional subtract mode (a - b) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    assign s_bit  = a_q[0] ^ b_q[0] ^ c_q;
    assign c_next = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

    // Result bits enter at the MSB so the first (LSB) bit ends up at position 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = s_bit;
        end else begin : g_res_wn
            assign res_shift = {s_bit, res_q[WIDTH-1:1]};
        end
    endgenerate

`ifdef SERIAL_ADDER_SUB_EN
    // a - b as a + ~b + 1; a final carry of 1 means no borrow.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b_load;
                    c_d     = c_load;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_next;
                res_d = res_shift;
                cnt_d = cnt_q + ONE;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = res_shift;
                    cout_d  = c_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=1 and WIDTH=8 instances against an arithmetic model.
module tb_serial_adder;

`ifdef SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub1 = 1'b0;
    logic       sub8 = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub1),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    serial_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {cout, sum} as the plain arithmetic result of the requested operation.
    function automatic logic [8:0] model8(input logic [7:0] ta, input logic [7:0] tb,
                                          input logic tc, input logic ts);
        logic [7:0] nb;
        nb = ~tb;
        if (ts && SUB_EN)
            return {1'b0, ta} + {1'b0, nb} + 9'd1;
        return {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drives start in the current cycle (may be the DONE cycle for back-to-back) and returns in
    // the cycle where done is observed. inj >= 0 fires an ignored start pulse at that RUN cycle.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic ts, input int inj, input string tag);
        logic [8:0] prev;
        logic [8:0] exp;
        int lat;
        int busy_cnt;
        prev = {cout8, sum8};
        exp  = model8(ta, tb, tc, ts);
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = ts;
`endif
        step();
        start8 = 1'b0;
        check({tag, "_busy_after_start"}, {31'd0, busy8}, 32'd1);
        check({tag, "_no_done_in_run"}, {31'd0, done8}, 32'd0);
        check({tag, "_hold_prev"}, {23'd0, cout8, sum8}, {23'd0, prev});
        // Operand changes during RUN must not matter.
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        lat = 0;
        busy_cnt = 0;
        while (!done8 && lat < 50) begin
            if (busy8) busy_cnt++;
            if (lat == inj) begin
                start8 = 1'b1;
                a8 = 8'h55;
            end
            step();
            start8 = 1'b0;
            lat++;
        end
        check({tag, "_latency"}, lat, 32'd8);
        check({tag, "_busy_cycles"}, busy_cnt, 32'd8);
        check({tag, "_busy_in_done"}, {31'd0, busy8}, 32'd0);
        check({tag, "_result"}, {23'd0, cout8, sum8}, {23'd0, exp});
    endtask

    task automatic idle_after_done(input string tag);
        step();
        check({tag, "_done_fell"}, {31'd0, done8}, 32'd0);
        check({tag, "_idle_not_busy"}, {31'd0, busy8}, 32'd0);
    endtask

    initial begin
        int watch_done;
        logic [7:0] ra, rb;
        logic rc, rs;

        repeat (3) step();
        check("rst_w8_state", {28'd0, busy8, done8, cout8, 1'b0}, 32'd0);
        check("rst_w8_sum", {24'd0, sum8}, 32'd0);
        check("rst_w1_state", {28'd0, busy1, done1, cout1, sum1}, 32'd0);
        rst = 1'b0;
        step();

        // WIDTH=1: registered full adder, done one cycle after the start edge.
        for (int i = 0; i < 8; i++) begin
            logic [1:0] fa;
            a1 = i[0]; b1 = i[1]; cin1 = i[2]; start1 = 1'b1;
            fa = {1'b0, i[0]} + {1'b0, i[1]} + {1'b0, i[2]};
            step();
            start1 = 1'b0;
            check("w1_busy", {31'd0, busy1}, 32'd1);
            step();
            check("w1_done", {31'd0, done1}, 32'd1);
            check("w1_result", {30'd0, cout1, sum1}, {30'd0, fa});
            step();
            check("w1_done_fell", {31'd0, done1}, 32'd0);
        end

        op8(8'h0F, 8'h01, 1'b0, 1'b0, -1, "t2");
        idle_after_done("t2");

        op8(8'hFF, 8'h01, 1'b0, 1'b0, -1, "t3a");
        op8(8'hFF, 8'hFF, 1'b1, 1'b0, -1, "t3b");
        idle_after_done("t3b");

        op8(8'h10, 8'h20, 1'b0, 1'b0, 3, "t4");
        idle_after_done("t4");

        // Reset four cycles into RUN aborts the operation without a done pulse.
        a8 = 8'h33; b8 = 8'h44; cin8 = 1'b1; start8 = 1'b1;
        step();
        start8 = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_outputs", {28'd0, busy8, done8, cout8, 1'b0}, 32'd0);
        check("t5_rst_sum", {24'd0, sum8}, 32'd0);
        watch_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) watch_done++;
            step();
        end
        check("t5_no_activity_after_rst", watch_done, 32'd0);
        op8(8'h12, 8'h34, 1'b1, 1'b0, -1, "t5_restart");
        idle_after_done("t5_restart");

        if (SUB_EN) begin
            op8(8'h05, 8'h07, 1'b0, 1'b1, -1, "t6a");
            op8(8'h07, 8'h05, 1'b1, 1'b1, -1, "t6b");
            idle_after_done("t6b");
        end

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = SUB_EN ? 1'($urandom) : 1'b0;
            op8(ra, rb, rc, rs, -1, "rand");
            if ($urandom_range(0, 1) == 0) idle_after_done("rand");
        end
        idle_after_done("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
